keypad_entry_buffer: RTL and testbench
======================================

# keypad_entry_buffer

Parametrised successor to the keypad front end: debounces an N-key one-hot/priority keypad, encodes the highest pressed key, and stores each new press sequentially into one of several per-channel digit buffers selected by a mode input. It replaces the ripple T-flip-flop sequencing and the 1-to-2 mode demux with a single synchronous block. It sits between the raw keypad pins and the code-compare/display logic.

## Interface
- `NUM_KEYS`, 10, number of key inputs (≥2); `KW = clog2(NUM_KEYS)`.
- `DEPTH`, 4, digits stored per channel (≥1); `IW = max(1, clog2(DEPTH))`, `CNTW = clog2(DEPTH+1)`.
- `CHANNELS`, 2, number of independent digit buffers (≥1); `CW = max(1, clog2(CHANNELS))`.
- `DEBOUNCE`, 3, cycles a sample must stay unchanged before acceptance (≥1).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `key_in` in NUM_KEYS: raw key levels; bit k high = key k pressed.
- `chan_sel` in CW: destination channel for the next accepted press.
- `clear` in 1: synchronous clear of the channel addressed by `chan_sel`.
- `rd_chan` in CW, `rd_idx` in IW: read address.
- `rd_digit` out KW: stored key code at (`rd_chan`, `rd_idx`), combinational.
- `rd_valid` out 1: high when `rd_chan < CHANNELS` and `rd_idx < count` of that channel.
- `key_code` out KW+1: debounced key; MSB = valid (any key), LSBs = code.
- `press_pulse` out 1: one-cycle strobe per accepted press.
- `drop_pulse` out 1: one-cycle strobe when a press targets a full channel.
- `count` out CHANNELS*CNTW: per-channel digit count, channel c at `[c*CNTW +: CNTW]`.
- `full` out CHANNELS: bit c high when count of channel c equals DEPTH.

## Operation
- Encoding: `s = {|key_in, index of highest set bit}`; no key gives `s = 0`. Multiple keys: highest index wins.
- Debounce: register `cand <= s`; counter `cnt` clears to 0 when `s != cand`, else increments saturating at DEBOUNCE. When `cnt == DEBOUNCE`, `stable <= cand`. `key_code = stable`.
- Press event: `stable` changes from invalid (MSB 0) to valid. Valid-to-valid change (slide from key 3 to key 5 without release) updates `key_code` only; no event, no write. Release (valid→invalid) produces no event.
- On press event (same edge `stable` updates), `chan_sel` sampled: if channel not full, write code to `mem[chan][count]`, increment count, assert `press_pulse`. If full, no write, count unchanged, assert `drop_pulse` (not `press_pulse`).
- `clear`: count of channel `chan_sel` ← 0 at next edge; memory contents need not be zeroed (masked by `rd_valid`).
- Clear and press to the same channel in the same cycle: clear wins, press discarded, neither pulse asserted.
- `chan_sel >= CHANNELS` at press: press discarded, `drop_pulse` asserted. `clear` with out-of-range `chan_sel`: no effect.
- Read: `rd_digit = 0` whenever `rd_valid` is low.

## Timing
- Reset (`rst` low, asynchronous): `cand`, `cnt`, `stable`, all counts, `press_pulse`, `drop_pulse` = 0; `key_code = 0`, `full = 0`, `rd_valid = 0`. Reset mid-debounce discards progress; a held key must fully re-debounce after release of reset.
- Press latency: `key_in` stable before edge 0 (from idle) → `cand` loaded at edge 0, `cnt` reaches DEBOUNCE at edge DEBOUNCE, `stable`/`key_code`, write, `press_pulse` at edge DEBOUNCE+1 (edge 4 for default).
- Glitch shorter than DEBOUNCE+1 cycles: never reaches `stable`.
- `press_pulse`/`drop_pulse`: registered, high exactly one cycle per event.
- `count`/`full` reflect a write or clear from the edge it occurs; `rd_digit`/`rd_valid` follow combinationally.

## Test plan
- Reset, hold `key_in = 10'b0000100000` from before edge 0, `chan_sel = 0` → `press_pulse` high after edge 4 only, `key_code = 5'b10101`, count0 = 1, `rd_digit(0,0) = 5`.
- 2-cycle glitch on key 7, then idle → no `press_pulse`, `key_code` stays 0, counts unchanged.
- Keys 1, 9 (with 0 and 9 both high → code 9), 2, 4 into channel 1 with releases between, then key 6 → count1 = 4, `full[1] = 1`, fifth press gives `drop_pulse`, digits read 1,9,2,4; `rd_idx` beyond count gives `rd_valid = 0`, `rd_digit = 0`.
- Hold key 3 through debounce, slide to key 8 without release → `key_code` 3→8 after DEBOUNCE+1 cycles, single `press_pulse`, count increments once.
- `clear` to channel 0 in the same cycle a press targets channel 0 → count0 = 0, no pulses; repeat with press on channel 1 → count0 = 0, count1 increments, `press_pulse` high.
- Drop `rst` low at edge 2 of a debounce with key held, release → counts 0, `press_pulse` appears DEBOUNCE+1 edges after reset release.

Source files
------------

// File: rtl/keypad_entry_buffer.sv
// Keypad front end: priority-encodes raw keys, debounces the code, and appends
// each new press to one of CHANNELS digit buffers selected by chan_sel.
module keypad_entry_buffer #(
  parameter  int NUM_KEYS = 10,
  parameter  int DEPTH    = 4,
  parameter  int CHANNELS = 2,
  parameter  int DEBOUNCE = 3,
  localparam int KW   = $clog2(NUM_KEYS),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW = $clog2(DEPTH + 1),
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_KEYS-1:0]      key_in,
  input  logic [CW-1:0]            chan_sel,
  input  logic                     clear,
  input  logic [CW-1:0]            rd_chan,
  input  logic [IW-1:0]            rd_idx,
  output logic [KW-1:0]            rd_digit,
  output logic                     rd_valid,
  output logic [KW:0]              key_code,
  output logic                     press_pulse,
  output logic                     drop_pulse,
  output logic [CHANNELS*CNTW-1:0] count,
  output logic [CHANNELS-1:0]      full
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  logic [KW:0]      s;
  logic [KW:0]      cand;
  logic [KW:0]      stable;
  logic [DW-1:0]    cnt;
  logic [CNTW-1:0]  cnt_ch [CHANNELS];
  logic [KW-1:0]    mem    [CHANNELS][DEPTH];

  logic press_evt;
  logic chan_ok;
  logic full_sel;
  logic accept;
  logic drop;
  logic rd_ok;

  // Highest set key index wins; the loop's last assignment has priority.
  always_comb begin
    s = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (key_in[k]) s = {1'b1, KW'(k)};
    end
  end

  assign press_evt = (cnt == DW'(DEBOUNCE)) && !stable[KW] && cand[KW];
  assign chan_ok   = 32'(chan_sel) < 32'(CHANNELS);
  assign full_sel  = chan_ok && (cnt_ch[chan_sel] == CNTW'(DEPTH));
  // A clear on the targeted channel swallows a coincident press silently.
  assign accept    = press_evt && chan_ok && !clear && !full_sel;
  assign drop      = press_evt && (!chan_ok || (!clear && full_sel));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand        <= '0;
      cnt         <= '0;
      stable      <= '0;
      press_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) cnt_ch[c] <= '0;
    end else begin
      cand <= s;
      if (s != cand)                 cnt <= '0;
      else if (cnt != DW'(DEBOUNCE)) cnt <= cnt + 1'b1;
      if (cnt == DW'(DEBOUNCE))      stable <= cand;

      press_pulse <= accept;
      drop_pulse  <= drop;

      if (clear && chan_ok)  cnt_ch[chan_sel] <= '0;
      else if (accept)       cnt_ch[chan_sel] <= cnt_ch[chan_sel] + 1'b1;
    end
  end

  // Digit storage is not reset; stale entries are hidden by rd_valid.
  always_ff @(posedge clk) begin
    if (accept) mem[chan_sel][cnt_ch[chan_sel][IW-1:0]] <= cand[KW-1:0];
  end

  assign key_code = stable;

  always_comb begin
    count = '0;
    full  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      count[c*CNTW +: CNTW] = cnt_ch[c];
      full[c]               = (cnt_ch[c] == CNTW'(DEPTH));
    end
  end

  assign rd_ok    = 32'(rd_chan) < 32'(CHANNELS);
  assign rd_valid = rd_ok && (CNTW'(rd_idx) < cnt_ch[rd_chan]);
  assign rd_digit = rd_valid ? mem[rd_chan][rd_idx] : '0;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer with default parameters.
module tb_keypad_entry_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key_in;
  logic       chan_sel;
  logic       clear;
  logic       rd_chan;
  logic [1:0] rd_idx;
  logic [3:0] rd_digit;
  logic       rd_valid;
  logic [4:0] key_code;
  logic       press_pulse;
  logic       drop_pulse;
  logic [5:0] count;
  logic [1:0] full;

  int n_checks = 0;
  int n_fail   = 0;
  int n_press  = 0;
  int n_drop   = 0;
  int base_p;
  int base_d;

  keypad_entry_buffer #(
    .NUM_KEYS(10), .DEPTH(4), .CHANNELS(2), .DEBOUNCE(3)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .chan_sel(chan_sel), .clear(clear),
    .rd_chan(rd_chan), .rd_idx(rd_idx), .rd_digit(rd_digit), .rd_valid(rd_valid),
    .key_code(key_code), .press_pulse(press_pulse), .drop_pulse(drop_pulse),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse) n_press++;
    if (drop_pulse)  n_drop++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input logic [9:0] keys, input logic ch);
    chan_sel = ch;
    key_in   = keys;
    tick(8);
    key_in   = '0;
    tick(8);
  endtask

  task automatic read_at(input logic ch, input logic [1:0] idx);
    rd_chan = ch;
    rd_idx  = idx;
    #1;
  endtask

  initial begin
    rst = 1'b0; key_in = '0; chan_sel = 1'b0; clear = 1'b0;
    rd_chan = 1'b0; rd_idx = '0;
    tick(2);
    check_eq("rst_key_code", 32'(key_code), 32'h0);
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_full", 32'(full), 32'h0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
    check_eq("rst_pulses", 32'({press_pulse, drop_pulse}), 32'h0);

    // Single press of key 5 into channel 0; latency to edge 4.
    rst = 1'b1;
    key_in = 10'b0000100000;
    tick(4);
    check_eq("lat_no_pulse_e3", 32'(press_pulse), 32'h0);
    check_eq("lat_code_e3", 32'(key_code), 32'h0);
    tick(1);
    check_eq("lat_pulse_e4", 32'(press_pulse), 32'h1);
    check_eq("lat_code_e4", 32'(key_code), 32'h15);
    check_eq("lat_count0", 32'(count[2:0]), 32'h1);
    read_at(1'b0, 2'd0);
    check_eq("lat_rd_valid", 32'(rd_valid), 32'h1);
    check_eq("lat_rd_digit", 32'(rd_digit), 32'h5);
    tick(1);
    check_eq("lat_pulse_e5", 32'(press_pulse), 32'h0);
    key_in = '0;
    tick(8);
    check_eq("release_code", 32'(key_code), 32'h0);

    // Two-cycle glitch on key 7.
    base_p = n_press;
    key_in = 10'b0010000000;
    tick(2);
    key_in = '0;
    tick(8);
    check_eq("glitch_no_press", 32'(n_press - base_p), 32'h0);
    check_eq("glitch_code", 32'(key_code), 32'h0);
    check_eq("glitch_count", 32'(count), 32'h1);

    // Fill channel 1, then overflow it.
    base_p = n_press;
    press_release(10'b0000000010, 1'b1);
    press_release(10'b1000000001, 1'b1);
    press_release(10'b0000000100, 1'b1);
    press_release(10'b0000010000, 1'b1);
    check_eq("fill_presses", 32'(n_press - base_p), 32'h4);
    check_eq("fill_count1", 32'(count[5:3]), 32'h4);
    check_eq("fill_full", 32'(full), 32'h2);
    base_p = n_press;
    base_d = n_drop;
    press_release(10'b0001000000, 1'b1);
    check_eq("ovf_drop", 32'(n_drop - base_d), 32'h1);
    check_eq("ovf_no_press", 32'(n_press - base_p), 32'h0);
    check_eq("ovf_count1", 32'(count[5:3]), 32'h4);
    read_at(1'b1, 2'd0); check_eq("rd1_0", 32'({rd_valid, rd_digit}), 32'h11);
    read_at(1'b1, 2'd1); check_eq("rd1_1", 32'({rd_valid, rd_digit}), 32'h19);
    read_at(1'b1, 2'd2); check_eq("rd1_2", 32'({rd_valid, rd_digit}), 32'h12);
    read_at(1'b1, 2'd3); check_eq("rd1_3", 32'({rd_valid, rd_digit}), 32'h14);
    read_at(1'b0, 2'd1); check_eq("rd_beyond", 32'({rd_valid, rd_digit}), 32'h00);

    // Slide from key 3 to key 8 without release.
    base_p = n_press;
    chan_sel = 1'b0;
    key_in = 10'b0000001000;
    tick(8);
    check_eq("slide_code3", 32'(key_code), 32'h13);
    key_in = 10'b0100000000;
    tick(4);
    check_eq("slide_hold3", 32'(key_code), 32'h13);
    tick(1);
    check_eq("slide_code8", 32'(key_code), 32'h18);
    check_eq("slide_one_press", 32'(n_press - base_p), 32'h1);
    check_eq("slide_count0", 32'(count[2:0]), 32'h2);
    key_in = '0;
    tick(8);
    read_at(1'b0, 2'd1); check_eq("slide_rd", 32'({rd_valid, rd_digit}), 32'h13);

    // Clear and press on channel 0 in the same cycle.
    base_p = n_press;
    base_d = n_drop;
    key_in = 10'b0000000100;
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_eq("clr_count0", 32'(count[2:0]), 32'h0);
    check_eq("clr_code", 32'(key_code), 32'h12);
    key_in = '0;
    tick(8);
    check_eq("clr_no_pulses", 32'((n_press - base_p) + (n_drop - base_d)), 32'h0);

    // Free channel 1, then press key 7 into it.
    chan_sel = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_eq("clr1_count", 32'(count), 32'h0);
    base_p = n_press;
    press_release(10'b0010000000, 1'b1);
    check_eq("ch1_press", 32'(n_press - base_p), 32'h1);
    check_eq("ch1_counts", 32'(count), 32'h8);
    read_at(1'b1, 2'd0); check_eq("ch1_rd", 32'({rd_valid, rd_digit}), 32'h17);

    // Reset in the middle of a debounce, key held throughout.
    chan_sel = 1'b0;
    key_in = 10'b0000010000;
    tick(3);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_count", 32'(count), 32'h0);
    check_eq("mid_rst_code", 32'(key_code), 32'h0);
    tick(2);
    rst = 1'b1;
    tick(4);
    check_eq("rerun_no_pulse", 32'(press_pulse), 32'h0);
    tick(1);
    check_eq("rerun_pulse", 32'(press_pulse), 32'h1);
    check_eq("rerun_count0", 32'(count[2:0]), 32'h1);
    key_in = '0;
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
